// File: rtl/port_device.sv
// port_device: CPU port-bus responder (DATA/STATUS window) with an RX FIFO and a TX holding register.
// Define RX_OVERFLOW_FLAG_EN to add a sticky RX overflow flag in STATUS bit2.
module port_device #(
  parameter int WORD_SIZE  = 16,
  parameter int BASE_ADDR  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WORD_SIZE-1:0] portaddr,
  input  logic [WORD_SIZE-1:0] portval,
  input  logic                 get_enable,
  input  logic                 set_enable,
  output logic [WORD_SIZE-1:0] portout,
  output logic                 port_hit,
  input  logic [WORD_SIZE-1:0] rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic [WORD_SIZE-1:0] tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [WORD_SIZE-1:0] DATA_ADDR = WORD_SIZE'(BASE_ADDR);
  localparam logic [WORD_SIZE-1:0] STAT_ADDR = DATA_ADDR + WORD_SIZE'(1);
  logic [WORD_SIZE-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_rptr, r_wptr;
  logic [CW-1:0]        r_count;
  logic [WORD_SIZE-1:0] r_portout, r_tx_data;
  logic                 r_port_hit, r_tx_valid;
  logic                 w_is_data, w_is_stat, w_rd, w_wr, w_empty, w_pop, w_push, w_tx_load, w_ovf;
  logic [WORD_SIZE-1:0] w_status;
  assign w_is_data = portaddr == DATA_ADDR;
  assign w_is_stat = portaddr == STAT_ADDR;
  assign w_empty   = r_count == '0;
  assign rx_ready  = r_count != CW'(FIFO_DEPTH);
  assign w_rd      = get_enable && (w_is_data || w_is_stat);
  // a read strobe always wins over a simultaneous write strobe
  assign w_wr      = set_enable && !get_enable;
  assign w_pop     = get_enable && w_is_data && !w_empty;
  assign w_push    = rx_valid && rx_ready;
  assign w_tx_load = w_wr && w_is_data && (!r_tx_valid || tx_ready);
  assign w_status  = {{(WORD_SIZE-3){1'b0}}, w_ovf, r_tx_valid, !w_empty};
  assign portout   = r_portout;
  assign port_hit  = r_port_hit;
  assign tx_data   = r_tx_data;
  assign tx_valid  = r_tx_valid;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_portout  <= '0;
      r_port_hit <= 1'b0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_rptr     <= '0;
      r_wptr     <= '0;
      r_count    <= '0;
    end else begin
      r_port_hit <= (get_enable || set_enable) && (w_is_data || w_is_stat);
      if (w_rd) r_portout <= w_is_data ? (w_empty ? '0 : r_mem[r_rptr]) : w_status;
      if (w_tx_load) begin
        r_tx_data  <= portval;
        r_tx_valid <= 1'b1;
      end else if (tx_ready) r_tx_valid <= 1'b0;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr] <= rx_data;
`ifdef RX_OVERFLOW_FLAG_EN
  logic r_ovf;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_ovf <= 1'b0;
    else r_ovf <= (rx_valid && !rx_ready) || (r_ovf && !(w_wr && w_is_stat));
  assign w_ovf = r_ovf;
`else
  assign w_ovf = 1'b0;
`endif
endmodule
